// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// ALU operation and ALU B-source selects, plus the packed control word.
// Pure declarations; no logic, no latency, no flow control.
package mips_ctrl_pkg;

   // Controller states; encodings 11..15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_ORIEXEC = 4'd9,
      S_ORIWB   = 4'd10
   } state_t;

   // instruction[31:26] values the controller understands
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // ALU operation requested from the ALU control block
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_OR    = 2'b11
   } aluop_t;

   // ALU B operand source
   typedef enum logic [1:0] {
      SRCB_B       = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SL2 = 2'b11
   } alusrcb_t;

   // Next-PC source
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

   // Complete set of datapath strobes and selects for one cycle
   typedef struct packed {
      logic     pcwrite;
      logic     pcwritecond;
      logic     iord;
      logic     memread;
      logic     memwrite;
      logic     memtoreg;
      logic     irwrite;
      logic     alusrca;
      logic     regwrite;
      logic     regdst;
      logic     zeroext;
      logic [1:0] pcsource;
      aluop_t   aluop;
      alusrcb_t alusrcb;
      logic     illegal_op;
   } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Classifies the 6-bit opcode into the instruction groups the controller uses.
// Latency: purely combinational.
// Backpressure: none; outputs follow opcode directly.
module opcode_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       rformat,
   output logic       lw,
   output logic       sw,
   output logic       beq,
   output logic       ori,
   output logic       illegal
);

   // One-hot classification; anything not recognised is flagged illegal
   always_comb begin
      rformat = 1'b0;
      lw      = 1'b0;
      sw      = 1'b0;
      beq     = 1'b0;
      ori     = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: rformat = 1'b1;
         OP_LW:    lw      = 1'b1;
         OP_SW:    sw      = 1'b1;
         OP_BEQ:   beq     = 1'b1;
         OP_ORI:   ori     = 1'b1;
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register plus per-state strobe decode.
// Latency: outputs are combinational from state; beq 3, R/sw/ori 4, lw 5 cycles.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR one cycle per low sample.
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       alusrca,
   output logic       regwrite,
   output logic       regdst,
   output logic       zeroext,
   output logic [1:0] pcsource,
   output logic [1:0] aluop,
   output logic [1:0] alusrcb,
   output logic [3:0] state,
   output logic       illegal_op
);

   state_t state_r;
   ctrl_t  ctl;

   logic op_rformat;
   logic op_lw;
   logic op_sw;
   logic op_beq;
   logic op_ori;
   logic op_illegal;

   opcode_decode u_opcode_decode (
      .opcode  (opcode),
      .rformat (op_rformat),
      .lw      (op_lw),
      .sw      (op_sw),
      .beq     (op_beq),
      .ori     (op_ori),
      .illegal (op_illegal)
   );

   // State register and transitions; reset drops straight back to FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (mem_ready)
                  state_r <= S_DECODE;
            end
            S_DECODE: begin
               if (op_lw || op_sw)
                  state_r <= S_MEMADR;
               else if (op_rformat)
                  state_r <= S_EXEC;
               else if (op_beq)
                  state_r <= S_BRANCH;
               else if (op_ori)
                  state_r <= S_ORIEXEC;
               else
                  state_r <= S_FETCH;
            end
            S_MEMADR: begin
               // opcode is held stable, so only lw or sw can arrive here
               if (op_lw)
                  state_r <= S_MEMRD;
               else if (op_sw)
                  state_r <= S_MEMWR;
               else
                  state_r <= S_FETCH;
            end
            S_MEMRD: begin
               if (mem_ready)
                  state_r <= S_MEMWB;
            end
            S_MEMWB:   state_r <= S_FETCH;
            S_MEMWR: begin
               if (mem_ready)
                  state_r <= S_FETCH;
            end
            S_EXEC:    state_r <= S_RWB;
            S_RWB:     state_r <= S_FETCH;
            S_BRANCH:  state_r <= S_FETCH;
            S_ORIEXEC: state_r <= S_ORIWB;
            S_ORIWB:   state_r <= S_FETCH;
            default:   state_r <= S_FETCH;
         endcase
      end
   end

   // Per-state strobe decode; every field not set for a state stays zero
   always_comb begin
      ctl = '0;
      case (state_r)
         S_FETCH: begin
            ctl.memread  = 1'b1;
            ctl.iord     = 1'b0;
            ctl.alusrca  = 1'b0;
            ctl.alusrcb  = SRCB_FOUR;
            ctl.aluop    = ALUOP_ADD;
            ctl.pcsource = PCSRC_ALU;
            // Latch IR and advance PC only on the cycle memory delivers,
            // and never while reset holds the machine
            ctl.irwrite  = mem_ready & ~reset;
            ctl.pcwrite  = mem_ready & ~reset;
         end
         S_DECODE: begin
            ctl.alusrca    = 1'b0;
            ctl.alusrcb    = SRCB_IMM_SL2;
            ctl.aluop      = ALUOP_ADD;
            ctl.illegal_op = op_illegal;
         end
         S_MEMADR: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = SRCB_IMM;
            ctl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctl.memread = 1'b1;
            ctl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctl.regwrite = 1'b1;
            ctl.memtoreg = 1'b1;
            ctl.regdst   = 1'b0;
         end
         S_MEMWR: begin
            ctl.memwrite = 1'b1;
            ctl.iord     = 1'b1;
         end
         S_EXEC: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = SRCB_B;
            ctl.aluop   = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctl.regwrite = 1'b1;
            ctl.regdst   = 1'b1;
            ctl.memtoreg = 1'b0;
         end
         S_BRANCH: begin
            ctl.alusrca     = 1'b1;
            ctl.alusrcb     = SRCB_B;
            ctl.aluop       = ALUOP_SUB;
            ctl.pcwritecond = 1'b1;
            ctl.pcsource    = PCSRC_ALUOUT;
         end
         S_ORIEXEC: begin
            ctl.alusrca = 1'b1;
            ctl.alusrcb = SRCB_IMM;
            ctl.zeroext = 1'b1;
            ctl.aluop   = ALUOP_OR;
         end
         S_ORIWB: begin
            ctl.regwrite = 1'b1;
            ctl.regdst   = 1'b0;
            ctl.memtoreg = 1'b0;
         end
         default: ctl = '0;
      endcase
   end

   assign pcwrite     = ctl.pcwrite;
   assign pcwritecond = ctl.pcwritecond;
   assign iord        = ctl.iord;
   assign memread     = ctl.memread;
   assign memwrite    = ctl.memwrite;
   assign memtoreg    = ctl.memtoreg;
   assign irwrite     = ctl.irwrite;
   assign alusrca     = ctl.alusrca;
   assign regwrite    = ctl.regwrite;
   assign regdst      = ctl.regdst;
   assign zeroext     = ctl.zeroext;
   assign pcsource    = ctl.pcsource;
   assign aluop       = ctl.aluop;
   assign alusrcb     = ctl.alusrcb;
   assign illegal_op  = ctl.illegal_op;
   assign state       = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction walks with literal
// expectations, then randomized opcodes, memory stalls and async resets
// checked every cycle against an instruction-level step-list model.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
   logic       irwrite, alusrca, regwrite, regdst, zeroext, illegal_op;
   logic [1:0] pcsource, aluop, alusrcb;
   logic [3:0] state;

   multicycle_control dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .memtoreg    (memtoreg),
      .irwrite     (irwrite),
      .alusrca     (alusrca),
      .regwrite    (regwrite),
      .regdst      (regdst),
      .zeroext     (zeroext),
      .pcsource    (pcsource),
      .aluop       (aluop),
      .alusrcb     (alusrcb),
      .state       (state),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] RT  = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] ORI = 6'b001101;
   localparam logic [5:0] JMP = 6'b000010;

   typedef struct packed {
      logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
      logic irwrite, alusrca, regwrite, regdst, zeroext;
      logic [1:0] pcsource, aluop, alusrcb;
      logic illegal_op;
   } outs_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   // Each instruction is a list of states it passes through; the wait states
   // (instruction fetch, data read, data write) repeat while memory is not ready.
   int         seq[6];
   int         len = 0;
   int         idx = 0;
   logic [5:0] cur_op = 6'd0;
   logic [5:0] next_op = 6'd0;
   bit         started = 1'b0;

   task automatic start_instr();
      cur_op = next_op;
      seq[0] = 0;
      seq[1] = 1;
      case (next_op)
         LW:  begin seq[2] = 2; seq[3] = 3; seq[4] = 4; len = 5; end
         SW:  begin seq[2] = 2; seq[3] = 5; len = 4; end
         RT:  begin seq[2] = 6; seq[3] = 7; len = 4; end
         BEQ: begin seq[2] = 8; len = 3; end
         ORI: begin seq[2] = 9; seq[3] = 10; len = 4; end
         default: len = 2;
      endcase
      idx = 0;
   endtask

   function automatic bit is_supported(input logic [5:0] op);
      return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ORI);
   endfunction

   // Datapath controls each state must present, straight from the state table
   function automatic outs_t expect_outs(input int st, input logic mr, input logic rst,
                                         input logic [5:0] op);
      outs_t e;
      e = '0;
      case (st)
         0: begin
            e.memread = 1'b1; e.alusrcb = 2'b01;
            e.irwrite = mr & ~rst; e.pcwrite = mr & ~rst;
         end
         1: begin e.alusrcb = 2'b11; e.illegal_op = !is_supported(op); end
         2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         3: begin e.memread = 1'b1; e.iord = 1'b1; end
         4: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
         5: begin e.memwrite = 1'b1; e.iord = 1'b1; end
         6: begin e.alusrca = 1'b1; e.aluop = 2'b10; end
         7: begin e.regwrite = 1'b1; e.regdst = 1'b1; end
         8: begin
            e.alusrca = 1'b1; e.aluop = 2'b01;
            e.pcwritecond = 1'b1; e.pcsource = 2'b01;
         end
         9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.zeroext = 1'b1; e.aluop = 2'b11; end
         10: e.regwrite = 1'b1;
         default: e = '0;
      endcase
      return e;
   endfunction

   // Model advance on each edge, restart on reset
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            start_instr();
            started = 1'b1;
         end else if (started) begin
            if (!((seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5) && !mem_ready)) begin
               idx++;
               if (idx == len)
                  start_instr();
            end
         end
      end
   end

   // Compare all outputs against the model once per cycle, mid low phase
   initial begin
      outs_t act, exp;
      forever begin
         @(negedge clk);
         #2;
         if (started) begin
            act = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                   irwrite, alusrca, regwrite, regdst, zeroext,
                   pcsource, aluop, alusrcb, illegal_op};
            exp = expect_outs(reset ? 0 : seq[idx], mem_ready, reset, cur_op);
            chk("model_state", {28'd0, state}, reset ? 32'd0 : seq[idx]);
            chk("model_outs", {14'd0, act}, {14'd0, exp});
            chk("mem_exclusive", {31'd0, memread & memwrite}, 32'd0);
         end
      end
   end

   // One directed cycle: drive in the low phase, then pin the state literally
   task automatic cyc(input logic mr, input int exp_st);
      @(negedge clk);
      #1;
      mem_ready = mr;
      opcode = cur_op;
      #2;
      chk("seq_state", {28'd0, state}, exp_st);
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] ops[8];
      ops[0] = RT; ops[1] = LW; ops[2] = SW; ops[3] = BEQ;
      ops[4] = ORI; ops[5] = JMP; ops[6] = 6'b111111;
      ops[7] = 6'($urandom);
      return ops[$urandom_range(0, 7)];
   endfunction

   initial begin
      // reset behaviour with memory ready
      next_op = LW;
      #1 reset = 1'b1;
      @(negedge clk);
      #1;
      mem_ready = 1'b1;
      opcode = cur_op;
      #2;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_irwrite", {31'd0, irwrite}, 32'd0);
      chk("rst_pcwrite", {31'd0, pcwrite}, 32'd0);
      chk("rst_memread", {31'd0, memread}, 32'd1);
      chk("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
      reset = 1'b0;
      #1;
      chk("fetch_irwrite", {31'd0, irwrite}, 32'd1);
      next_op = SW;

      // lw, no stalls: 0,1,2,3,4 then back to 0
      cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
      chk("lw_regwrite", {31'd0, regwrite}, 32'd1);
      chk("lw_memtoreg", {31'd0, memtoreg}, 32'd1);

      // sw with two stall cycles in MEMWR: 6 cycles total
      cyc(1, 0); next_op = BEQ;
      cyc(1, 1); cyc(1, 2);
      cyc(0, 5); chk("sw_memwrite0", {31'd0, memwrite}, 32'd1);
      cyc(0, 5); chk("sw_memwrite1", {31'd0, memwrite}, 32'd1);
      cyc(1, 5); chk("sw_memwrite2", {31'd0, memwrite}, 32'd1);

      // beq: 0,1,8
      cyc(1, 0); next_op = ORI;
      cyc(1, 1);
      cyc(1, 8);
      chk("beq_pcwritecond", {31'd0, pcwritecond}, 32'd1);
      chk("beq_aluop", {30'd0, aluop}, 32'd1);
      chk("beq_pcsource", {30'd0, pcsource}, 32'd1);

      // ori: 0,1,9,10
      cyc(1, 0); next_op = JMP;
      cyc(1, 1);
      cyc(1, 9);
      chk("ori_zeroext", {31'd0, zeroext}, 32'd1);
      chk("ori_aluop", {30'd0, aluop}, 32'd3);
      cyc(1, 10);
      chk("ori_regwrite", {31'd0, regwrite}, 32'd1);
      chk("ori_regdst", {31'd0, regdst}, 32'd0);

      // unsupported opcode: pulse in DECODE then straight back to FETCH
      cyc(1, 0); next_op = LW;
      cyc(1, 1);
      chk("ill_pulse", {31'd0, illegal_op}, 32'd1);
      chk("ill_writes", {29'd0, regwrite, memwrite, pcwritecond}, 32'd0);

      // lw interrupted by async reset while stalled in MEMRD
      cyc(1, 0); next_op = RT;
      cyc(1, 1); cyc(1, 2); cyc(0, 3);
      reset = 1'b1;
      #1;
      chk("async_rst_state", {28'd0, state}, 32'd0);
      mem_ready = 1'b1;
      #1;
      chk("async_rst_irwrite", {31'd0, irwrite}, 32'd0);
      chk("async_rst_pcwrite", {31'd0, pcwrite}, 32'd0);
      chk("async_rst_regwrite", {31'd0, regwrite}, 32'd0);
      @(posedge clk);
      #2;
      chk("async_rst_hold", {28'd0, state}, 32'd0);
      reset = 1'b0;

      // randomized instruction stream with stalls and occasional resets
      repeat (3000) begin
         @(negedge clk);
         #1;
         mem_ready = ($urandom_range(0, 3) != 0);
         opcode = cur_op;
         next_op = pick_op();
         if ($urandom_range(0, 60) == 0) begin
            #3;
            reset = 1'b1;
            #1;
            chk("rand_rst_state", {28'd0, state}, 32'd0);
            @(posedge clk);
            #2;
            reset = 1'b0;
         end
      end

      @(negedge clk);
      #4;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 opcode  in  6  instruction[31:26] from the instruction register; stable from DECODE until the next FETCH.
REQ-004 mem_ready  in  1  memory completion; sampled in FETCH, MEMRD and MEMWR.
REQ-005 pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst, zeroext  out  1 each  multicycle datapath strobes and selects.
REQ-006 pcsource  out  2  00 ALU result, 01 ALUOut register.
REQ-007 aluop  out  2  00 add, 01 sub, 10 funct field, 11 or.
REQ-008 alusrcb  out  2  00 B register, 01 constant 4, 10 extended immediate, 11 sign-extended immediate shifted left 2.
REQ-009 state  out  4  current state encoding, for debug.
REQ-010 illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode.

Function
REQ-011 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, ori 001101.
REQ-012 States SHALL be encoded as FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ORIEXEC=9, ORIWB=10.
REQ-013 Outputs SHALL be decoded combinationally from state; only irwrite and pcwrite also depend on mem_ready.
REQ-014 Any output not listed for a state SHALL be 0 in that state.
REQ-015 FETCH SHALL assert memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00 and pcsource=00.
REQ-016 FETCH SHALL assert irwrite=pcwrite=mem_ready, and SHALL stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-017 DECODE SHALL assert alusrca=0, alusrcb=11 and aluop=00.
REQ-018 DECODE SHALL go to MEMADR on lw/sw, EXEC on R-type, BRANCH on beq and ORIEXEC on ori.
REQ-019 On any other opcode, DECODE SHALL pulse illegal_op and go to FETCH.
REQ-020 MEMADR SHALL assert alusrca=1, alusrcb=10 and aluop=00, then go to MEMRD for lw or MEMWR for sw.
REQ-021 MEMRD SHALL assert memread=1 and iord=1, holding until mem_ready=1, then go to MEMWB.
REQ-022 MEMWB SHALL assert regwrite=1, memtoreg=1 and regdst=0, then go to FETCH.
REQ-023 MEMWR SHALL assert memwrite=1 and iord=1, holding until mem_ready=1, then go to FETCH.
REQ-024 EXEC SHALL assert alusrca=1, alusrcb=00 and aluop=10, then go to RWB.
REQ-025 RWB SHALL assert regwrite=1, regdst=1 and memtoreg=0, then go to FETCH.
REQ-026 BRANCH SHALL assert alusrca=1, alusrcb=00, aluop=01, pcwritecond=1 and pcsource=01, then go to FETCH.
REQ-027 ORIEXEC SHALL assert alusrca=1, alusrcb=10, zeroext=1 and aluop=11, then go to ORIWB.
REQ-028 ORIWB SHALL assert regwrite=1, regdst=0 and memtoreg=0, then go to FETCH.
REQ-029 With mem_ready held at 1, instruction latency SHALL be: beq 3 cycles; R-type, sw and ori 4 cycles; lw 5 cycles.
REQ-030 Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to the instruction.
REQ-031 Unused encodings 11-15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-032 memread and memwrite SHALL never be asserted in the same cycle.

Reset
REQ-033 reset=1 SHALL force state=FETCH immediately, regardless of clk.
REQ-034 During reset, outputs SHALL be the FETCH values with irwrite=pcwrite=0, regardless of mem_ready.
REQ-035 Reset asserted mid-instruction SHALL abandon that instruction with no further regwrite or memwrite.

Structure
REQ-036 The state encodings, opcode constants, aluop encoding and alusrcb encoding SHALL live in shared package mips_ctrl_pkg.
REQ-037 Opcode classification SHALL be one combinational sub-module, opcode_decode, with outputs rformat, lw, sw, beq, ori and illegal.
REQ-038 The state register and the output decode SHALL be in multicycle_control.

Verification
REQ-039 lw (100011), mem_ready=1 -> state 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-040 sw (101011), mem_ready=0 for 2 cycles in MEMWR -> state 5 held 3 cycles with memwrite=1; total 6 cycles; regwrite never 1.
REQ-041 beq (000100) -> state 0,1,8,0; pcwritecond=1, aluop=01 and pcsource=01 in state 8.
REQ-042 ori (001101) -> state 9 drives zeroext=1 and aluop=11; state 10 drives regwrite=1 and regdst=0.
REQ-043 opcode 000010 -> illegal_op=1 for one cycle in DECODE, then FETCH; no write strobe asserted.
REQ-044 reset asserted asynchronously mid-cycle in MEMRD -> state=0 before the next clk edge; irwrite=pcwrite=0 while reset=1.
